fp_writeback_queue: RTL
=======================

# fp_writeback_queue

Write-back collector for the floating-point register file's single write port. It merges two result streams: single-cycle FP ALU results and backpressured results from multi-cycle FP units (div/sqrt). It registers the selected write toward the register file. A per-register pending scoreboard lets issue logic detect RAW/WAW hazards against outstanding long-latency operations.

## Interface
Parameters:
- DATA_WIDTH, 32, FP register width.
- ADDR_WIDTH, 5, register address width (32 registers).
- FIFO_DEPTH, 4, slow-result queue entries; power of two, ≥2.

Ports:
- in_Clk  input  1  clock, all state on rising edge.
- in_Rst_N  input  1  reset; asynchronous, active-low.
- in_fast_Valid / in_fast_Addr / in_fast_Data  input  1 / ADDR_WIDTH / DATA_WIDTH  FP ALU result; no backpressure, must always be accepted.
- in_slow_Valid / in_slow_Addr / in_slow_Data  input  1 / ADDR_WIDTH / DATA_WIDTH  multi-cycle unit result.
- out_slow_Ready  output  1  queue can accept a slow result this cycle.
- in_issue_En / in_issue_Addr  input  1 / ADDR_WIDTH  long-latency op issued; marks its destination pending.
- out_issue_Stall  output  1  issue refused (destination already pending).
- in_check_A / in_check_B  input  ADDR_WIDTH  source addresses to check.
- out_busy_A / out_busy_B  output  1  checked register is pending.
- out_wr_En / out_wr_Addr / out_wr_Data  output  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port.

## Operation
- Slow enqueue: a slow result enqueues at the tail on an edge where in_slow_Valid && out_slow_Ready.
  - out_slow_Ready = !full. It is combinational from the occupancy count only and never depends on in_slow_Valid.
- Write selection is evaluated each cycle:
  - If in_fast_Valid, the fast result is selected. The FIFO head stays put.
  - Otherwise, if the FIFO is non-empty, the head is selected and dequeued.
  - Otherwise nothing is selected.
- Selection registers into out_wr_*.
  - out_wr_En = 1 for exactly one cycle per selected result.
  - A registered source flag records fast vs slow.
- Simultaneous enqueue and dequeue in one cycle: occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO: no enqueue; dequeue still allowed. Ready rises the cycle after a dequeue.
- Empty FIFO with no fast result: out_wr_En = 0. No write-through from in_slow_* to out_wr_* in the same cycle.
- Scoreboard (pending[2^ADDR_WIDTH]):
  - Set: pending[in_issue_Addr] is set on an edge with in_issue_En && !out_issue_Stall.
  - Stall: out_issue_Stall = in_issue_En && pending[in_issue_Addr], combinational. A stalled issue does not change state.
  - Clear: pending[out_wr_Addr] is cleared on an edge where out_wr_En && source == slow.
  - Set and clear of the same address on the same edge: set wins.
  - Fast writes never touch pending.
  - out_busy_X = pending[in_check_X], combinational.
- Starvation of the slow path under continuous fast writes is accepted. Issue logic guarantees gaps.

## Timing
- Fast latency: result valid at edge N → out_wr_En high in the cycle after edge N+1. The register file captures it at edge N+2.
- Slow latency from an empty FIFO with no fast traffic:
  - Enqueue at edge N.
  - Head selected in the cycle after N, so out_wr_En is high after edge N+1.
- Scoreboard clear takes effect at the same edge the register file captures the data. out_busy drops exactly when the new value is readable.
- Reset (asynchronous, in_Rst_N = 0):
  - FIFO empty, pointers 0, pending all 0.
  - out_wr_En = 0, out_wr_Addr = 0, out_wr_Data = 0, source flag = fast.
  - Combinational outputs during reset: out_slow_Ready = 1, out_busy_* = 0, out_issue_Stall = 0.
  - Reset mid-operation discards queued results and pending bits. No write is emitted on release.

## Configuration
- FP_WB_SCOREBOARD_EN:
  - Defined: the pending array, issue stall and busy lookups are built as above.
  - Undefined: the pending array is not instantiated. out_busy_A / out_busy_B / out_issue_Stall are tied 0 and in_issue_* / in_check_* are ignored. Queue and arbitration behaviour is identical.

## Test plan
- Reset, then fast write addr 3 data 0x3F800000 → out_wr_En=1, Addr=3, Data=0x3F800000 one cycle after the acceptance edge; nothing on the next cycle.
- Issue addr 7, then slow result addr 7 data 0x40490FDB:
  - out_busy for addr 7 = 1 from issue until the edge after the write pulse, then 0.
  - Re-issue of addr 7 while pending → out_issue_Stall=1.
- Fill FIFO with 4 slow results (addr 1..4) while fast valid is held → out_slow_Ready=0 after the 4th. Drop fast → writes 1,2,3,4 in order on consecutive cycles, ready returns.
- Fast and slow valid together for 3 cycles → three fast writes first, then the slow entry; FIFO count peaks at 3.
- Scoreboard edge case: clear and re-issue of addr 9 on the same edge → pending[9] stays 1.
- Assert reset with 2 entries queued and 2 pending → after release: no writes, out_slow_Ready=1, all busy=0.

Source files
------------

// File: rtl/fp_writeback_queue.sv
`default_nettype none
// fp_writeback_queue: merges single-cycle FP ALU results with queued multi-cycle results onto one
// register-file write port; the pending scoreboard is built only when FP_WB_SCOREBOARD_EN is defined.
module fp_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_fast_Valid,
  input  logic [ADDR_WIDTH-1:0] in_fast_Addr,
  input  logic [DATA_WIDTH-1:0] in_fast_Data,
  input  logic                  in_slow_Valid,
  input  logic [ADDR_WIDTH-1:0] in_slow_Addr,
  input  logic [DATA_WIDTH-1:0] in_slow_Data,
  output logic                  out_slow_Ready,
  input  logic                  in_issue_En,
  input  logic [ADDR_WIDTH-1:0] in_issue_Addr,
  output logic                  out_issue_Stall,
  input  logic [ADDR_WIDTH-1:0] in_check_A,
  input  logic [ADDR_WIDTH-1:0] in_check_B,
  output logic                  out_busy_A,
  output logic                  out_busy_B,
  output logic                  out_wr_En,
  output logic [ADDR_WIDTH-1:0] out_wr_Addr,
  output logic [DATA_WIDTH-1:0] out_wr_Data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  enq;
  logic                  deq;
  logic                  wr_src_slow;

  logic                  sel_en;
  logic                  sel_slow;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign full           = (count == CNT_FULL);
  assign empty          = (count == '0);
  assign out_slow_Ready = !full;
  assign enq            = in_slow_Valid && !full;
  // Fast results own the port; the head only drains in cycles without one.
  assign deq            = !in_fast_Valid && !empty;

  always_ff @(posedge in_Clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= in_slow_Addr;
      q_data[wr_ptr] <= in_slow_Data;
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      if (enq && !deq)      count <= count + CNT_ONE;
      else if (!enq && deq) count <= count - CNT_ONE;
    end
  end

  always_comb begin
    sel_en   = 1'b0;
    sel_slow = 1'b0;
    sel_addr = in_fast_Addr;
    sel_data = in_fast_Data;
    if (in_fast_Valid) begin
      sel_en = 1'b1;
    end else if (!empty) begin
      sel_en   = 1'b1;
      sel_slow = 1'b1;
      sel_addr = q_addr[rd_ptr];
      sel_data = q_data[rd_ptr];
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      out_wr_En   <= 1'b0;
      out_wr_Addr <= '0;
      out_wr_Data <= '0;
      wr_src_slow <= 1'b0;
    end else begin
      out_wr_En <= sel_en;
      if (sel_en) begin
        out_wr_Addr <= sel_addr;
        out_wr_Data <= sel_data;
        wr_src_slow <= sel_slow;
      end
    end
  end

`ifdef FP_WB_SCOREBOARD_EN
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0] pending;
  logic                issue_set;

  assign out_issue_Stall = in_issue_En && pending[in_issue_Addr];
  assign issue_set       = in_issue_En && !pending[in_issue_Addr];
  assign out_busy_A      = pending[in_check_A];
  assign out_busy_B      = pending[in_check_B];

  // Set is applied after clear so a same-edge re-issue keeps the bit.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      pending <= '0;
    end else begin
      if (out_wr_En && wr_src_slow) pending[out_wr_Addr] <= 1'b0;
      if (issue_set)                pending[in_issue_Addr] <= 1'b1;
    end
  end
`else
  logic unused_sb;

  assign out_issue_Stall = 1'b0;
  assign out_busy_A      = 1'b0;
  assign out_busy_B      = 1'b0;
  assign unused_sb       = ^{in_issue_En, in_issue_Addr, in_check_A, in_check_B, wr_src_slow};
`endif

endmodule

`default_nettype wire
